// File: rtl/mig_ui_responder_if.sv
// Application-side MIG UI bundle: command, write-data and read-return channels.
interface mig_ui_responder_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_end;
  logic         app_wdf_wren;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_end;
  logic         app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_end, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_end, app_rd_data_valid
  );
endinterface

// File: rtl/mig_ui_responder.sv
// BRAM-backed stand-in for the DDR3 MIG user interface: in-order command queue,
// decoupled write-data queue, fixed-latency read return and programmable app_rdy stalls.
//
// state     | meaning
// ST_CALIB  | counting down calibration delay, UI not ready
// ST_RUN    | calibrated, commands and data accepted
module mig_ui_responder #(
  parameter int DEPTH_WORDS    = 4096,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 64,
  parameter int CMD_FIFO_DEPTH = 16,
  parameter int WDF_DEPTH      = 4,
  parameter int STALL_PERIOD   = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  mig_ui_responder_if.slave    app,
  output logic                 init_calib_complete,
  output logic [3:0]           err_out
);
  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int CPW  = $clog2(CMD_FIFO_DEPTH);
  localparam int WPW  = $clog2(WDF_DEPTH);
  localparam int CALW = $clog2(CALIB_CYCLES + 1);
  localparam int SW   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int L    = RD_LATENCY;

  localparam logic [CALW-1:0] CAL_INIT   = CALW'(CALIB_CYCLES);
  localparam logic [SW-1:0]   STALL_LAST = SW'(STALL_PERIOD - 1);
  localparam logic [CPW:0]    CMD_FULL   = (CPW + 1)'(CMD_FIFO_DEPTH);
  localparam logic [WPW:0]    WDF_FULL   = (WPW + 1)'(WDF_DEPTH);

  typedef enum logic {ST_CALIB = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic          rd;
    logic          oor;
    logic [AW-1:0] idx;
  } cmd_t;

  state_t state_q, state_d;
  logic [CALW-1:0] cal_cnt_q, cal_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            stall_d;
  logic            app_rdy_q, app_rdy_d;
  logic            wdf_rdy_q, wdf_rdy_d;
  logic [3:0]      err_q, err_d;

  logic [CPW-1:0]  cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [CPW:0]    cmd_cnt_q, cmd_cnt_d;
  logic [WPW-1:0]  wdf_wr_ptr_q, wdf_wr_ptr_d, wdf_rd_ptr_q, wdf_rd_ptr_d;
  logic [WPW:0]    wdf_cnt_q, wdf_cnt_d;

  logic [L-1:0]    rd_vld_q, rd_vld_d;
  logic            rd_zero_q, rd_zero_d;
  logic [127:0]    rd_pipe_q [1:L-1];
  logic [127:0]    rd_pipe_d [1:L-1];

  cmd_t            cmd_mem [CMD_FIFO_DEPTH];
  logic [127:0]    wdf_data_mem [WDF_DEPTH];
  logic [15:0]     wdf_mask_mem [WDF_DEPTH];
  logic [127:0]    mem [DEPTH_WORDS];
  logic [127:0]    bram_dout;

  logic [31:0]     in_idx_full;
  logic            in_oor, cmd_ok, cmd_acc, cmd_push, wdf_push;
  cmd_t            cmd_in, head;
  logic            head_vld, rd_issue, wr_issue;

  always_comb begin
    in_idx_full = {8'd0, app.app_addr[26:3]};
    in_oor      = in_idx_full >= 32'(DEPTH_WORDS);
    cmd_ok      = (app.app_cmd == 3'b000) || (app.app_cmd == 3'b001);
    cmd_acc     = app.app_en && app_rdy_q;
    cmd_push    = cmd_acc && cmd_ok;
    wdf_push    = app.app_wdf_wren && wdf_rdy_q;
    cmd_in.rd   = app.app_cmd[0];
    cmd_in.oor  = in_oor;
    cmd_in.idx  = in_idx_full[AW-1:0];

    head     = cmd_mem[cmd_rd_ptr_q];
    head_vld = cmd_cnt_q != '0;
    rd_issue = head_vld && head.rd;
    // A write at the head blocks everything behind it until its data beat exists.
    wr_issue = head_vld && !head.rd && (wdf_cnt_q != '0);
  end

  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    case (state_q)
      ST_CALIB: begin
        cal_cnt_d = cal_cnt_q - 1'b1;
        if (cal_cnt_q <= CALW'(1)) state_d = ST_RUN;
      end
      ST_RUN: cal_cnt_d = '0;
      default: state_d = ST_CALIB;
    endcase

    stall_cnt_d = stall_cnt_q;
    stall_d     = 1'b0;
    if (STALL_PERIOD != 0) begin
      stall_cnt_d = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
      stall_d     = stall_cnt_d == STALL_LAST;
    end

    cmd_wr_ptr_d = cmd_push ? cmd_wr_ptr_q + 1'b1 : cmd_wr_ptr_q;
    cmd_rd_ptr_d = (rd_issue || wr_issue) ? cmd_rd_ptr_q + 1'b1 : cmd_rd_ptr_q;
    cmd_cnt_d    = cmd_cnt_q + (CPW + 1)'(cmd_push) - (CPW + 1)'(rd_issue || wr_issue);
    wdf_wr_ptr_d = wdf_push ? wdf_wr_ptr_q + 1'b1 : wdf_wr_ptr_q;
    wdf_rd_ptr_d = wr_issue ? wdf_rd_ptr_q + 1'b1 : wdf_rd_ptr_q;
    wdf_cnt_d    = wdf_cnt_q + (WPW + 1)'(wdf_push) - (WPW + 1)'(wr_issue);

    // Ready flags look one cycle ahead so they come straight from flops.
    app_rdy_d = (state_d == ST_RUN) && (cmd_cnt_d != CMD_FULL) && !stall_d;
    wdf_rdy_d = (state_d == ST_RUN) && (wdf_cnt_d != WDF_FULL);

    err_d = err_q;
    if (cmd_acc) begin
      if (!cmd_ok) begin
        err_d[2] = 1'b1;
      end else begin
        if (app.app_addr[2:0] != 3'b000) err_d[1] = 1'b1;
        if (in_oor) err_d[0] = 1'b1;
      end
    end
    if (wdf_push && !app.app_wdf_end) err_d[3] = 1'b1;

    rd_vld_d  = {rd_vld_q[L-2:0], rd_issue};
    rd_zero_d = rd_issue && head.oor;
    rd_pipe_d = rd_pipe_q;
    rd_pipe_d[1] = rd_zero_q ? '0 : bram_dout;
    for (int i = 2; i < L; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q      <= ST_CALIB;
      cal_cnt_q    <= CAL_INIT;
      stall_cnt_q  <= '0;
      app_rdy_q    <= 1'b0;
      wdf_rdy_q    <= 1'b0;
      err_q        <= '0;
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_cnt_q    <= '0;
      wdf_wr_ptr_q <= '0;
      wdf_rd_ptr_q <= '0;
      wdf_cnt_q    <= '0;
      rd_vld_q     <= '0;
      rd_zero_q    <= 1'b0;
      for (int i = 1; i < L; i++) rd_pipe_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cal_cnt_q    <= cal_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      app_rdy_q    <= app_rdy_d;
      wdf_rdy_q    <= wdf_rdy_d;
      err_q        <= err_d;
      cmd_wr_ptr_q <= cmd_wr_ptr_d;
      cmd_rd_ptr_q <= cmd_rd_ptr_d;
      cmd_cnt_q    <= cmd_cnt_d;
      wdf_wr_ptr_q <= wdf_wr_ptr_d;
      wdf_rd_ptr_q <= wdf_rd_ptr_d;
      wdf_cnt_q    <= wdf_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_zero_q    <= rd_zero_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  // Storage arrays carry no reset so they map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr_q] <= cmd_in;
    if (wdf_push) begin
      wdf_data_mem[wdf_wr_ptr_q] <= app.app_wdf_data;
      wdf_mask_mem[wdf_wr_ptr_q] <= app.app_wdf_mask;
    end
    if (wr_issue && !head.oor) begin
      for (int b = 0; b < 16; b++) begin
        if (!wdf_mask_mem[wdf_rd_ptr_q][b]) mem[head.idx][b*8 +: 8] <= wdf_data_mem[wdf_rd_ptr_q][b*8 +: 8];
      end
    end
    if (rd_issue && !head.oor) bram_dout <= mem[head.idx];
  end

  assign app.app_rdy           = app_rdy_q;
  assign app.app_wdf_rdy       = wdf_rdy_q;
  assign app.app_rd_data       = rd_pipe_q[L-1];
  assign app.app_rd_data_valid = rd_vld_q[L-1];
  assign app.app_rd_data_end   = rd_vld_q[L-1];
  assign init_calib_complete   = state_q == ST_RUN;
  assign err_out               = err_q;
endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench: dut0 has no app_rdy stalls, dut1 stalls app_rdy every 5th cycle.
module tb_mig_ui_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mig_ui_responder_if u0();
  mig_ui_responder_if u1();
  logic       calib0, calib1;
  logic [3:0] err0, err1;

  mig_ui_responder #(.STALL_PERIOD(0)) dut0 (
    .clk_in(clk), .rst_in_n(rst_n), .app(u0), .init_calib_complete(calib0), .err_out(err0));
  mig_ui_responder #(.STALL_PERIOD(5)) dut1 (
    .clk_in(clk), .rst_in_n(rst_n), .app(u1), .init_calib_complete(calib1), .err_out(err1));

  logic [127:0] rd0_q[$];
  int           rd0_cyc[$];
  logic [127:0] rd1_q[$];
  int           end_bad = 0;

  always @(negedge clk) begin
    if (u0.app_rd_data_valid) begin
      rd0_q.push_back(u0.app_rd_data);
      rd0_cyc.push_back(cyc);
    end
    if (u1.app_rd_data_valid) rd1_q.push_back(u1.app_rd_data);
    if (u0.app_rd_data_end !== u0.app_rd_data_valid) end_bad++;
    if (u1.app_rd_data_end !== u1.app_rd_data_valid) end_bad++;
  end

  localparam logic [127:0] D1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;

  function automatic logic [127:0] pat(input int i);
    return {32'(i), 32'h1234_5678 ^ 32'(i), ~32'(i), 32'hCAFE_0000 + 32'(i)};
  endfunction

  task automatic idle_inputs();
    u0.app_addr = '0; u0.app_cmd = '0; u0.app_en = 1'b0;
    u0.app_wdf_data = '0; u0.app_wdf_end = 1'b1; u0.app_wdf_wren = 1'b0; u0.app_wdf_mask = '0;
    u1.app_addr = '0; u1.app_cmd = '0; u1.app_en = 1'b0;
    u1.app_wdf_data = '0; u1.app_wdf_end = 1'b1; u1.app_wdf_wren = 1'b0; u1.app_wdf_mask = '0;
  endtask

  task automatic send_cmd0(input logic [2:0] c, input logic [26:0] a, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    u0.app_cmd = c; u0.app_addr = a; u0.app_en = 1'b1;
    while (!u0.app_rdy && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL cmd_accept_timeout got app_rdy=0 want 1"); end
    @(posedge clk); #1;
    acc_cyc = cyc;
    u0.app_en = 1'b0;
  endtask

  task automatic send_data0(input logic [127:0] d, input logic [15:0] m, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    u0.app_wdf_data = d; u0.app_wdf_mask = m; u0.app_wdf_end = e; u0.app_wdf_wren = 1'b1;
    while (!u0.app_wdf_rdy && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL data_accept_timeout got app_wdf_rdy=0 want 1"); end
    @(posedge clk); #1;
    u0.app_wdf_wren = 1'b0; u0.app_wdf_end = 1'b1;
  endtask

  task automatic wait_rd0(input int target);
    int n;
    n = 0;
    while (rd0_q.size() < target && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({calib0, u0.app_rdy, u0.app_wdf_rdy, u0.app_rd_data_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl0 got %b want 0000", {calib0, u0.app_rdy, u0.app_wdf_rdy, u0.app_rd_data_valid});
    end
    checks++;
    if (u0.app_rd_data !== 128'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", u0.app_rd_data); end
    checks++;
    if (err0 !== 4'h0 || err1 !== 4'h0) begin errors++; $display("FAIL reset_err got %h/%h want 0/0", err0, err1); end
    checks++;
    if ({calib1, u1.app_rdy, u1.app_wdf_rdy} !== 3'b0) begin
      errors++; $display("FAIL reset_ctrl1 got %b want 000", {calib1, u1.app_rdy, u1.app_wdf_rdy});
    end
  endtask

  task automatic test_calibration();
    int bad;
    logic exp;
    bad = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      exp = (i >= 64);
      if ({calib0, u0.app_rdy, u0.app_wdf_rdy} !== {3{exp}} || calib1 !== exp) bad++;
      if (i == 63) begin
        checks++;
        if ({calib0, u0.app_rdy, u0.app_wdf_rdy} !== 3'b000) begin
          errors++; $display("FAIL calib_cycle63 got %b want 000", {calib0, u0.app_rdy, u0.app_wdf_rdy});
        end
      end
      if (i == 64) begin
        checks++;
        if ({calib0, u0.app_rdy, u0.app_wdf_rdy} !== 3'b111) begin
          errors++; $display("FAIL calib_cycle64 got %b want 111", {calib0, u0.app_rdy, u0.app_wdf_rdy});
        end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL calib_window got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_basic();
    int a, r;
    rd0_q.delete(); rd0_cyc.delete();
    send_cmd0(3'b000, 27'h40, a);
    send_data0(D1, 16'h0000, 1'b1);
    send_cmd0(3'b001, 27'h40, r);
    wait_rd0(1);
    checks++;
    if (rd0_q.size() != 1) begin errors++; $display("FAIL basic_count got %0d want 1", rd0_q.size()); end
    else begin
      checks++;
      if (rd0_q[0] !== D1) begin errors++; $display("FAIL basic_data got %h want %h", rd0_q[0], D1); end
      checks++;
      if (rd0_cyc[0] - r != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", rd0_cyc[0] - r); end
    end
    checks++;
    if (err0 !== 4'h0) begin errors++; $display("FAIL basic_err got %h want 0", err0); end
  endtask

  task automatic test_masked();
    int a;
    logic [127:0] exp;
    exp = {{15{8'hFF}}, 8'h00};
    rd0_q.delete(); rd0_cyc.delete();
    send_cmd0(3'b000, 27'h80, a);
    send_data0({128{1'b1}}, 16'h0000, 1'b1);
    send_cmd0(3'b000, 27'h80, a);
    send_data0(128'h0, 16'hFFFE, 1'b1);
    send_cmd0(3'b001, 27'h80, a);
    wait_rd0(1);
    checks++;
    if (rd0_q.size() != 1 || rd0_q[0] !== exp) begin
      errors++; $display("FAIL masked_data got n=%0d %h want %h", rd0_q.size(), (rd0_q.size() > 0) ? rd0_q[0] : 128'h0, exp);
    end
  endtask

  task automatic test_decoupled();
    int a;
    logic [127:0] dv [3];
    dv[0] = 128'h1111_AAAA_0000_0001_1111_AAAA_0000_0001;
    dv[1] = 128'h2222_BBBB_0000_0002_2222_BBBB_0000_0002;
    dv[2] = 128'h3333_CCCC_0000_0003_3333_CCCC_0000_0003;
    rd0_q.delete(); rd0_cyc.delete();
    send_cmd0(3'b000, 27'h100, a);
    send_cmd0(3'b000, 27'h108, a);
    send_cmd0(3'b000, 27'h110, a);
    send_cmd0(3'b001, 27'h100, a);
    repeat (20) @(negedge clk);
    checks++;
    if (rd0_q.size() != 0) begin errors++; $display("FAIL decoupled_blocked got %0d beats want 0", rd0_q.size()); end
    for (int i = 0; i < 3; i++) send_data0(dv[i], 16'h0000, 1'b1);
    send_cmd0(3'b001, 27'h108, a);
    send_cmd0(3'b001, 27'h110, a);
    wait_rd0(3);
    checks++;
    if (rd0_q.size() != 3) begin errors++; $display("FAIL decoupled_count got %0d want 3", rd0_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rd0_q[i] !== dv[i]) begin errors++; $display("FAIL decoupled_data%0d got %h want %h", i, rd0_q[i], dv[i]); end
      end
    end
  endtask

  task automatic test_errors();
    int a;
    logic [127:0] e;
    e = 128'h0BAD_F00D_5555_AAAA_0123_4567_89AB_CDEF;
    rd0_q.delete(); rd0_cyc.delete();
    send_cmd0(3'b001, 27'h8000, a);
    wait_rd0(1);
    checks++;
    if (rd0_q.size() != 1 || rd0_q[0] !== 128'h0) begin
      errors++; $display("FAIL oor_read got n=%0d %h want 1 beat of 0", rd0_q.size(), (rd0_q.size() > 0) ? rd0_q[0] : 128'h1);
    end
    checks++;
    if (err0 !== 4'b0001) begin errors++; $display("FAIL err_oor got %b want 0001", err0); end
    send_cmd0(3'b010, 27'h40, a);
    repeat (8) @(negedge clk);
    checks++;
    if (err0 !== 4'b0101 || rd0_q.size() != 1) begin
      errors++; $display("FAIL err_badcmd got %b beats=%0d want 0101 beats=1", err0, rd0_q.size());
    end
    send_cmd0(3'b001, 27'h41, a);
    wait_rd0(2);
    checks++;
    if (rd0_q.size() != 2 || rd0_q[1] !== D1 || err0 !== 4'b0111) begin
      errors++; $display("FAIL err_unaligned got n=%0d err=%b want n=2 data=%h err=0111", rd0_q.size(), err0, D1);
    end
    send_cmd0(3'b000, 27'h200, a);
    send_data0(e, 16'h0000, 1'b0);
    send_cmd0(3'b001, 27'h200, a);
    wait_rd0(3);
    checks++;
    if (rd0_q.size() != 3 || rd0_q[2] !== e || err0 !== 4'b1111) begin
      errors++; $display("FAIL err_noend got n=%0d err=%b want n=3 data=%h err=1111", rd0_q.size(), err0, e);
    end
    checks++;
    if (end_bad != 0) begin errors++; $display("FAIL rd_end_equals_valid got %0d bad cycles want 0", end_bad); end
  endtask

  task automatic test_back_pressure();
    int ci, di, n, last_low, gap_bad, n_low, bad_data;
    rd1_q.delete();
    ci = 0; di = 0; n = 0;
    while ((ci < 1000 || di < 1000) && n < 4000) begin
      @(negedge clk);
      u1.app_en = (ci < 1000); u1.app_cmd = 3'b000; u1.app_addr = 27'(ci * 8);
      u1.app_wdf_wren = (di < 1000); u1.app_wdf_data = pat(di); u1.app_wdf_mask = '0; u1.app_wdf_end = 1'b1;
      if (u1.app_en && u1.app_rdy) ci++;
      if (u1.app_wdf_wren && u1.app_wdf_rdy) di++;
      n++;
    end
    @(negedge clk);
    u1.app_en = 1'b0; u1.app_wdf_wren = 1'b0;
    checks++;
    if (ci != 1000 || di != 1000) begin errors++; $display("FAIL bp_fill got cmds=%0d data=%0d want 1000/1000", ci, di); end

    ci = 0; n = 0; last_low = -1; gap_bad = 0; n_low = 0;
    while (ci < 1000 && n < 4000) begin
      @(negedge clk);
      u1.app_en = 1'b1; u1.app_cmd = 3'b001; u1.app_addr = 27'(ci * 8);
      if (!u1.app_rdy) begin
        if (last_low >= 0 && cyc - last_low != 5) gap_bad++;
        last_low = cyc;
        n_low++;
      end else begin
        ci++;
      end
      n++;
    end
    @(negedge clk);
    u1.app_en = 1'b0;
    n = 0;
    while (rd1_q.size() < 1000 && n < 300) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++;
    if (gap_bad != 0 || n_low < 200) begin
      errors++; $display("FAIL bp_stall_period got gap_bad=%0d lows=%0d want gap_bad=0 lows>=200", gap_bad, n_low);
    end
    checks++;
    if (rd1_q.size() != 1000) begin errors++; $display("FAIL bp_count got %0d want 1000", rd1_q.size()); end
    bad_data = 0;
    for (int i = 0; i < rd1_q.size() && i < 1000; i++) begin
      if (rd1_q[i] !== pat(i)) begin
        if (bad_data == 0) $display("FAIL bp_data idx %0d got %h want %h", i, rd1_q[i], pat(i));
        bad_data++;
      end
    end
    checks++;
    if (bad_data != 0) begin errors++; $display("FAIL bp_data_total got %0d bad beats want 0", bad_data); end
  endtask

  task automatic test_reset_inflight();
    int k, n;
    rd0_q.delete(); rd0_cyc.delete();
    k = 0; n = 0;
    @(negedge clk);
    u0.app_cmd = 3'b001; u0.app_addr = 27'h40; u0.app_en = 1'b1;
    while (k < 4 && n < 50) begin
      if (u0.app_rdy) k++;
      @(posedge clk); #1;
      u0.app_addr = 27'h40 + 27'(k * 8);
      n++;
    end
    u0.app_en = 1'b0;
    rst_n = 1'b0;
    checks++;
    if (k != 4 || rd0_q.size() != 0) begin
      errors++; $display("FAIL inflight_setup got accepted=%0d beats=%0d want 4/0", k, rd0_q.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (u0.app_rd_data_valid !== 1'b0 || u0.app_rdy !== 1'b0) begin
      errors++; $display("FAIL inflight_in_reset got valid=%b rdy=%b want 0/0", u0.app_rd_data_valid, u0.app_rdy);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (rd0_q.size() != 0) begin errors++; $display("FAIL inflight_flushed got %0d beats want 0", rd0_q.size()); end
    checks++;
    if (err0 !== 4'h0 || calib0 !== 1'b0) begin
      errors++; $display("FAIL inflight_err_cleared got err=%b calib=%b want 0000/0", err0, calib0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_calibration();
    test_basic();
    test_masked();
    test_decoupled();
    test_errors();
    test_back_pressure();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
